// File: rtl/decoder_arb_pkg.sv
// decoder_arb_pkg
//   Shared constants and state encoding for the round-robin arbiter that
//   sequences the 3-to-8 active-low select decoder.
//   No ports (package).
package decoder_arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   // Decoder output polarity is active-low, so "no line live" is all ones.
   localparam logic [N_REQ-1:0] GNT_NONE = 8'hFF;

   // Pointer value after reset: the scan starts at ptr+1, so requester 0
   // is favoured first.
   localparam logic [IDX_W-1:0] PTR_RESET = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8
//   Combinational round-robin pick among 8 requesters.
//   Ports:
//     req [7:0]  in   active-high request levels
//     ptr [2:0]  in   index of the last winner; scan starts at ptr+1
//     any        out  high when at least one request is set
//     idx [2:0]  out  winning index (meaningful only when any=1)
module rr_pick8
   import decoder_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0]   start;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   off;

   always_comb begin
      start = ptr + 3'd1;
      // Concatenating req with itself turns the rotate-right into a plain
      // part-select: rot[i] = req[(start + i) mod 8].
      dbl   = {req, req};
      rot   = dbl[{1'b0, start} +: N_REQ];
      any   = |req;
      // Priority encoder: lowest set bit of the rotated vector wins.
      off   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      // Undo the rotation; 3-bit addition wraps mod 8 naturally.
      idx   = start + off;
   end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
//   Round-robin arbiter sharing one 3-to-8 active-low select decoder among
//   8 requesters. Every grant is followed by one dead (GAP) cycle so the
//   downstream minterm/NAND logic never sees two decoder lines live.
//   Ports:
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     en           in   arbitration enable (only gates new grants)
//     req [7:0]    in   active-high level requests
//     gnt_n [7:0]  out  active-low one-hot grant, 8'hFF = none (registered)
//     gnt_idx [2:0]out  index of current or last grant (registered)
//     busy         out  high while a grant is live (registered)
//     timeout      out  one-cycle pulse on preemption (registered)
//   Build option: define ARB_TIMEOUT_EN to enable hold-timeout preemption
//   after MAX_HOLD grant cycles when another requester is waiting. Without
//   it a grant lasts until its request drops and timeout stays 0.
module decoder_rr_arbiter
   import decoder_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt_n,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             busy,
   output logic             timeout
);

   // Reject illegal configurations at elaboration time.
   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_params
      $error("decoder_rr_arbiter: MAX_HOLD must be 2..255 and below 2**CNT_W");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [N_REQ-1:0] gnt_n_q, gnt_n_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             other_req;
`endif

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_idx_d = gnt_idx_q;
      gnt_n_d   = gnt_n_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      other_req = |(req & ~(8'd1 << gnt_idx_q));
`endif

      case (state_q)
         // GAP re-arbitrates exactly like IDLE; its only role is to be the
         // single dead cycle that follows every release.
         ST_IDLE, ST_GAP: begin
            if (en && pick_any) begin
               state_d   = ST_GRANT;
               gnt_idx_d = pick_idx;
               gnt_n_d   = ~(8'd1 << pick_idx);
               busy_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end else begin
               state_d = ST_IDLE;
               gnt_n_d = GNT_NONE;
               busy_d  = 1'b0;
            end
         end

         // en is deliberately not looked at here: a live grant is only
         // ended by its owner (or by preemption in the timeout build).
         ST_GRANT: begin
            if (!req[gnt_idx_q]) begin
               state_d = ST_GAP;
               gnt_n_d = GNT_NONE;
               busy_d  = 1'b0;
               ptr_d   = gnt_idx_q;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(MAX_HOLD - 1) && other_req) begin
               state_d   = ST_GAP;
               gnt_n_d   = GNT_NONE;
               busy_d    = 1'b0;
               ptr_d     = gnt_idx_q;
               timeout_d = 1'b1;
            end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         default: begin
            state_d = ST_IDLE;
            gnt_n_d = GNT_NONE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PTR_RESET;
         gnt_idx_q <= '0;
         gnt_n_q   <= GNT_NONE;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_n_q   <= gnt_n_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign gnt_n   = gnt_n_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;
   import decoder_arb_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt_n;
   logic [2:0] gnt_idx;
   logic       busy;
   logic       timeout;

   always #5 clk = ~clk;

   decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt_n   (gnt_n),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .timeout (timeout)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] g, input logic [2:0] i,
                             input logic b, input logic t);
      check({tag, ".gnt_n"},   gnt_n,            g);
      check({tag, ".gnt_idx"}, {5'd0, gnt_idx},  {5'd0, i});
      check({tag, ".busy"},    {7'd0, busy},     {7'd0, b});
      check({tag, ".timeout"}, {7'd0, timeout},  {7'd0, t});
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock and sample 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       en;
      logic [7:0] req;
      logic [7:0] gnt_n;
      logic [2:0] idx;
      logic       busy;
      logic       timeout;
   } vec_t;

   localparam int N_VEC = 23;
   vec_t vecs[N_VEC];

   // Watchdog: the test is fixed-length, this only catches a stuck simulator.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Inputs applied before the edge -> outputs expected after the edge.
      // Single request, release, GAP, IDLE.
      vecs[0]  = '{1'b1, 8'h01, 8'hFE, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 8'h01, 8'hFE, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0};
      // Wrap: finish grant 6, then 8'h21 picks 0 before 5.
      vecs[5]  = '{1'b1, 8'h40, 8'hBF, 3'd6, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h00, 8'hFF, 3'd6, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h00, 8'hFF, 3'd6, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h21, 8'hFE, 3'd0, 1'b1, 1'b0};
      // Owner 0 drops while 5 waits: 5 only after the GAP cycle.
      vecs[9]  = '{1'b1, 8'h20, 8'hFF, 3'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'h20, 8'hDF, 3'd5, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 8'h00, 8'hFF, 3'd5, 1'b0, 1'b0};
      // Enable low blocks new grants; raising it grants 4 one clock later.
      vecs[12] = '{1'b0, 8'h10, 8'hFF, 3'd5, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 8'h10, 8'hFF, 3'd5, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h10, 8'hFF, 3'd5, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 8'h10, 8'hEF, 3'd4, 1'b1, 1'b0};
      // Lowering en during GRANT leaves the grant intact.
      vecs[16] = '{1'b0, 8'h10, 8'hEF, 3'd4, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 8'h10, 8'hEF, 3'd4, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 8'h00, 8'hFF, 3'd4, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 8'h00, 8'hFF, 3'd4, 1'b0, 1'b0};
      // Request dropped in the cycle its grant appears: exactly one grant cycle.
      vecs[20] = '{1'b1, 8'h08, 8'hF7, 3'd3, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 8'h00, 8'hFF, 3'd3, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 8'h00, 8'hFF, 3'd3, 1'b0, 1'b0};

      // ---- reset held with all requests asserted ----
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'hFF;
      repeat (3) step();
      check_outs("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      req   = 8'h00;

      // ---- table-driven vectors ----
      for (int v = 0; v < N_VEC; v++) begin
         en  = vecs[v].en;
         req = vecs[v].req;
         step();
         check_outs($sformatf("vec%0d", v), vecs[v].gnt_n, vecs[v].idx,
                    vecs[v].busy, vecs[v].timeout);
      end

      // ---- asynchronous reset mid-grant ----
      en  = 1'b1;
      req = 8'h01;
      step();
      check("midrst.pre_gnt_n", gnt_n, 8'hFE);
      rst_n = 1'b0;
      #2;  // well before the next rising edge
      check_outs("midrst", 8'hFF, 3'd0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      req   = 8'h00;
      step();

      // ---- fairness: order 0..7,0 with one dead cycle between grants ----
      for (int k = 0; k < 9; k++) exp_q.push_back(8'(k % 8));
      for (int k = 0; k < 9; k++) begin
         logic [7:0] e;
         e   = exp_q.pop_front();
         req = 8'hFF;
         step();
         check($sformatf("fair%0d.idx", k), {5'd0, gnt_idx}, e);
         check($sformatf("fair%0d.gnt_n", k), gnt_n, ~(8'd1 << e[2:0]));
         repeat (2) step();
         check($sformatf("fair%0d.hold", k), gnt_n, ~(8'd1 << e[2:0]));
         req = 8'hFF & ~(8'd1 << e[2:0]);
         step();
         check($sformatf("fair%0d.gap", k), gnt_n, 8'hFF);
      end
      check("fair.queue_left", 8'(exp_q.size()), 8'd0);

      // ---- hold timeout (MAX_HOLD=4), req=8'h09 held ----
      req = 8'h00;
      do_reset();
      req = 8'h09;
      for (int c = 1; c <= 4; c++) begin
         step();
         check_outs($sformatf("to_hold%0d", c), 8'hFE, 3'd0, 1'b1, 1'b0);
      end
`ifdef ARB_TIMEOUT_EN
      step();
      check_outs("to_preempt", 8'hFF, 3'd0, 1'b0, 1'b1);
      step();
      check_outs("to_next", 8'hF7, 3'd3, 1'b1, 1'b0);
`else
      for (int c = 5; c <= 12; c++) begin
         step();
         check_outs($sformatf("to_hold%0d", c), 8'hFE, 3'd0, 1'b1, 1'b0);
      end
`endif

      // ---- final report ----
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 active-low select decoder among 8 requesters.
- Registers the winning 3-bit index and drives the one-hot, active-low grant bus `gnt_n`, matching the codebase's decoder output polarity.
- Sits ahead of minterm/NAND function logic that consumes decoder lines; sequences which line is live.
- Optional hold-timeout preempts a requester that holds the resource too long.

Parameters:
- MAX_HOLD, 16: max GRANT cycles before preemption (timeout build only); legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  arbitration enable; high permits new grants
- req  input  8  request per requester, active-high, level
- gnt_n  output  8  active-low one-hot grant; 8'hFF = none
- gnt_idx  output  3  index of current or last grant
- busy  output  1  high while a grant is live
- timeout  output  1  one-cycle pulse on preemption

Behaviour:
- Reset (async, rst_n=0): state IDLE, ptr=3'd7, gnt_n=8'hFF, gnt_idx=0, busy=0, timeout=0, hold counter=0. This is immediate even mid-grant.
- All outputs are registered.
- States: IDLE, GRANT, GAP.
- Pick rule: scan indices ptr+1, ptr+2, … ptr+8 (mod 8); the first with req set wins. The scan is combinational from the current ptr.
- IDLE: if en=1 and any req bit is set, the next edge loads gnt_idx=pick, drives gnt_n=~(1<<pick), sets busy=1, clears the counter, and enters GRANT. Latency is 1 clk from sampled req to grant.
- GRANT:
  - Grant holds while req[gnt_idx]=1.
  - The counter increments each cycle and saturates at MAX_HOLD.
  - When req[gnt_idx] is sampled 0, the next edge sets gnt_n=8'hFF, busy=0, ptr=gnt_idx, and enters GAP.
  - The en input is ignored in GRANT; a live grant is never cut by en.
- GAP: exactly one dead cycle (no grant), guaranteeing break-before-make. Next edge behaves as IDLE, re-picking from the updated ptr.
  - A pick is made only if en=1 and some req bit is set; that goes straight to GRANT.
  - Otherwise the next state is IDLE.
- Requests arriving in the same cycle the owner drops are not granted until after GAP.
- gnt_idx retains the last winner while idle.
- At most one gnt_n bit is ever low.
- A requester dropping req in the same cycle its grant appears still receives one grant cycle, then release follows.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when the counter equals MAX_HOLD-1 and any other req bit is set, the next edge forces release.
  - Release sets gnt_n=8'hFF, busy=0, ptr=gnt_idx, timeout=1 for one cycle, and enters GAP.
  - If no other requester is pending, the grant continues with the counter saturated.
- Undefined:
  - No preemption; the grant lasts until req drops.
  - timeout is tied 0.
  - The counter may be omitted.

Decomposition:
- Package decoder_arb_pkg:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
  - N_REQ=8, IDX_W=3
  - GNT_NONE=8'hFF
- Sub-module rr_pick8: combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Rotates req right by ptr+1, finds the lowest set bit with a priority encoder, and adds the offset back mod 8.
- Grant line generation is an inline active-low 3-to-8 decode of the next gnt_idx, registered.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF and toggle clk -> gnt_n=8'hFF, busy=0, timeout=0. Assert rst_n=0 mid-grant -> gnt_n=8'hFF before the next edge.
- Single request: req=8'h01 -> 1 clk later gnt_n=8'hFE, gnt_idx=0, busy=1. Drop req -> next clk gnt_n=8'hFF, one GAP cycle, then IDLE.
- Fairness: req=8'hFF, each grantee drops its req 3 cycles after grant and reasserts -> grant order 0,1,2,…,7,0, each followed by one dead cycle.
- Wrap: after grant 6 completes (ptr=6), req=8'h21 -> grant 0 (gnt_n=8'hFE), not 5. Then the next grant is 5.
- Enable: en=0, req=8'h10 -> gnt_n stays 8'hFF indefinitely. Raise en -> grant 4 after 1 clk. Lowering en during GRANT leaves the grant intact.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h09 held -> grant 0 for 4 cycles, timeout=1 for one cycle, GAP, then grant 3. Without the macro -> grant 0 persists and timeout stays 0.
